// File: rtl/video_pkg.sv
// Shared types and constants for the video test pattern generator.
package video_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    PAT_SOLID_RED  = 2'd0,
    PAT_COLOR_BARS = 2'd1,
    PAT_GREY_RAMP  = 2'd2,
    PAT_CHECKER    = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } tpg_state_e;

  // Colour bars, left to right: white, yellow, cyan, green, magenta, red, blue, black
  localparam pixel_t BAR_0 = 24'hFFFFFF;
  localparam pixel_t BAR_1 = 24'hFFFF00;
  localparam pixel_t BAR_2 = 24'h00FFFF;
  localparam pixel_t BAR_3 = 24'h00FF00;
  localparam pixel_t BAR_4 = 24'hFF00FF;
  localparam pixel_t BAR_5 = 24'hFF0000;
  localparam pixel_t BAR_6 = 24'h0000FF;
  localparam pixel_t BAR_7 = 24'h000000;

  localparam pixel_t SOLID_RED = 24'hFF0000;
  localparam pixel_t WHITE     = 24'hFFFFFF;
  localparam pixel_t BLACK     = 24'h000000;

  function automatic pixel_t bar_colour(input logic [2:0] idx);
    pixel_t c;
    case (idx)
      3'd0:    c = BAR_0;
      3'd1:    c = BAR_1;
      3'd2:    c = BAR_2;
      3'd3:    c = BAR_3;
      3'd4:    c = BAR_4;
      3'd5:    c = BAR_5;
      3'd6:    c = BAR_6;
      default: c = BAR_7;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/tpg_pixel_lut.sv
// Combinational pixel map: selected pattern plus position information -> RGB pixel.
// x carries the low 8 bits of the column (enough for the ramp and the 16-pixel
// checker tiles); y_tile is bit 4 of the row.
module tpg_pixel_lut
  import video_pkg::*;
(
  input  logic [1:0]  pattern,
  input  logic [7:0]  x,
  input  logic        y_tile,
  input  logic        frame_bit,
  input  logic [2:0]  bar_idx,
  output logic [23:0] pixel
);

  // Pick the colour for the requested pattern at this position
  always_comb begin
    pixel = BLACK;
    case (pattern_e'(pattern))
      PAT_SOLID_RED:  pixel = SOLID_RED;
      PAT_COLOR_BARS: pixel = bar_colour(bar_idx);
      PAT_GREY_RAMP:  pixel = {x, x, x};
      PAT_CHECKER:    pixel = (x[4] ^ y_tile ^ frame_bit) ? WHITE : BLACK;
      default:        pixel = BLACK;
    endcase
  end

endmodule

// File: rtl/video_test_pattern_gen.sv
// AXI4-Stream video test pattern generator. Produces frames of H_ACTIVE x V_ACTIVE
// pixels with tuser on the first pixel and tlast on the last pixel of each line.
// Output beats are registered: the LUT is driven with the position that will be
// presented next, so a new beat appears on the cycle after it is decided.
module video_test_pattern_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int LINE_GAP = 0
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [23:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic [15:0] frame_count
);

  localparam int XW    = $clog2(H_ACTIVE);
  localparam int YW    = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);
  localparam logic [7:0]    GAP_LAST = (LINE_GAP > 0) ? 8'(LINE_GAP - 1) : 8'd0;
  localparam int            Y_TILE_BIT = (YW > 4) ? 4 : 0;

  tpg_state_e    state, state_next;
  logic [XW-1:0] x, x_next;
  logic [YW-1:0] y, y_next;
  logic [BW-1:0] bar_cnt, bar_cnt_next;
  logic [2:0]    bar_idx, bar_idx_next;
  logic [7:0]    gap_cnt, gap_next;
  logic [1:0]    pattern, pattern_next;
  logic [15:0]   fc_next;
  logic          load_beat;
  logic          drop_beat;
  logic          xfer;
  logic [23:0]   lut_pixel;
  logic          y_tile;

  assign xfer   = m_axis_video_tvalid & m_axis_video_tready;
  assign y_tile = (YW > 4) ? y_next[Y_TILE_BIT] : 1'b0;

  tpg_pixel_lut u_lut (
    .pattern   (pattern_next),
    .x         (8'(x_next)),
    .y_tile    (y_tile),
    .frame_bit (fc_next[0]),
    .bar_idx   (bar_idx_next),
    .pixel     (lut_pixel)
  );

  // Next-state and counter advance: decides what position is presented next
  always_comb begin
    state_next   = state;
    x_next       = x;
    y_next       = y;
    bar_cnt_next = bar_cnt;
    bar_idx_next = bar_idx;
    gap_next     = gap_cnt;
    pattern_next = pattern;
    fc_next      = frame_count;
    load_beat    = 1'b0;
    drop_beat    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_next   = ST_ACTIVE;
          pattern_next = pattern_sel;
          x_next       = '0;
          y_next       = '0;
          bar_cnt_next = '0;
          bar_idx_next = '0;
          load_beat    = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          if (x == X_LAST) begin
            x_next       = '0;
            bar_cnt_next = '0;
            bar_idx_next = '0;
            if (y == Y_LAST) begin
              y_next  = '0;
              fc_next = frame_count + 16'd1;
              if (enable) begin
                pattern_next = pattern_sel;
                if (LINE_GAP > 0) begin
                  state_next = ST_GAP;
                  gap_next   = '0;
                  drop_beat  = 1'b1;
                end else begin
                  load_beat = 1'b1;
                end
              end else begin
                state_next = ST_IDLE;
                drop_beat  = 1'b1;
              end
            end else begin
              y_next = y + 1'b1;
              if (LINE_GAP > 0) begin
                state_next = ST_GAP;
                gap_next   = '0;
                drop_beat  = 1'b1;
              end else begin
                load_beat = 1'b1;
              end
            end
          end else begin
            x_next = x + 1'b1;
            if (bar_cnt == BAR_LAST) begin
              bar_cnt_next = '0;
              bar_idx_next = bar_idx + 3'd1;
            end else begin
              bar_cnt_next = bar_cnt + 1'b1;
            end
            load_beat = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next = ST_ACTIVE;
          gap_next   = '0;
          load_beat  = 1'b1;
        end else begin
          gap_next = gap_cnt + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered stream outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state               <= ST_IDLE;
      x                   <= '0;
      y                   <= '0;
      bar_cnt             <= '0;
      bar_idx             <= '0;
      gap_cnt             <= '0;
      pattern             <= '0;
      frame_count         <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tdata  <= '0;
      m_axis_video_tuser  <= 1'b0;
      m_axis_video_tlast  <= 1'b0;
    end else begin
      state       <= state_next;
      x           <= x_next;
      y           <= y_next;
      bar_cnt     <= bar_cnt_next;
      bar_idx     <= bar_idx_next;
      gap_cnt     <= gap_next;
      pattern     <= pattern_next;
      frame_count <= fc_next;
      if (load_beat) begin
        m_axis_video_tvalid <= 1'b1;
        m_axis_video_tdata  <= lut_pixel;
        m_axis_video_tuser  <= (x_next == '0) && (y_next == '0);
        m_axis_video_tlast  <= (x_next == X_LAST);
      end else if (drop_beat) begin
        m_axis_video_tvalid <= 1'b0;
        m_axis_video_tdata  <= '0;
        m_axis_video_tuser  <= 1'b0;
        m_axis_video_tlast  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_test_pattern_gen.sv
// Directed testbench for video_test_pattern_gen with a 16x4 frame. Two instances:
// one without line gaps and one with a 3-cycle gap after every line.
module tb_video_test_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;

  logic        aclk;
  logic        aresetn;
  logic        enable;
  logic [1:0]  sel;
  logic        tready;
  logic        which;

  logic        en0, en3;
  logic [23:0] data0, data3;
  logic        valid0, valid3, user0, user3, last0, last3;
  logic [15:0] fc0, fc3;

  logic [23:0] ob_data;
  logic        ob_valid, ob_user, ob_last;
  logic [15:0] ob_fc;

  int tests_run;
  int failures;

  logic [23:0] bd [0:255];
  logic        bu [0:255];
  logic        bl [0:255];
  int          idle_before [0:255];
  int          cyc_used;

  assign en0 = enable & ~which;
  assign en3 = enable & which;

  assign ob_data  = which ? data3  : data0;
  assign ob_valid = which ? valid3 : valid0;
  assign ob_user  = which ? user3  : user0;
  assign ob_last  = which ? last3  : last0;
  assign ob_fc    = which ? fc3    : fc0;

  video_test_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_GAP(0)) dut0 (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .enable              (en0),
    .pattern_sel         (sel),
    .m_axis_video_tdata  (data0),
    .m_axis_video_tvalid (valid0),
    .m_axis_video_tready (tready),
    .m_axis_video_tuser  (user0),
    .m_axis_video_tlast  (last0),
    .frame_count         (fc0)
  );

  video_test_pattern_gen #(.H_ACTIVE(H), .V_ACTIVE(V), .LINE_GAP(3)) dut3 (
    .aclk                (aclk),
    .aresetn             (aresetn),
    .enable              (en3),
    .pattern_sel         (sel),
    .m_axis_video_tdata  (data3),
    .m_axis_video_tvalid (valid3),
    .m_axis_video_tready (tready),
    .m_axis_video_tuser  (user3),
    .m_axis_video_tlast  (last3),
    .frame_count         (fc3)
  );

  // Free-running clock
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] exp_pix(input int s, input int x, input int y, input int f);
    logic [23:0] p;
    p = 24'h000000;
    case (s)
      0: p = 24'hFF0000;
      1: begin
        case (x / (H / 8))
          0: p = 24'hFFFFFF;
          1: p = 24'hFFFF00;
          2: p = 24'h00FFFF;
          3: p = 24'h00FF00;
          4: p = 24'hFF00FF;
          5: p = 24'hFF0000;
          6: p = 24'h0000FF;
          default: p = 24'h000000;
        endcase
      end
      2: p = {3{8'(x)}};
      default: p = ((((x >> 4) ^ (y >> 4) ^ f) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
    endcase
    return p;
  endfunction

  // Accept n beats, optionally with random tready; enable drops after drop_at beats.
  // Also checks that a stalled beat stays unchanged on the following cycle.
  task automatic applyStimulus(input int n, input bit rnd, input int drop_at);
    int cnt;
    int idle;
    bit stalled;
    logic [23:0] hd;
    logic hu, hl;
    cnt = 0;
    idle = 0;
    stalled = 0;
    hd = '0;
    hu = 1'b0;
    hl = 1'b0;
    cyc_used = 0;
    while (cnt < n && cyc_used < 2000) begin
      @(negedge aclk);
      cyc_used++;
      tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stalled) begin
        checkOutput("hold_valid", 32'(ob_valid), 32'd1);
        checkOutput("hold_data", 32'(ob_data), 32'(hd));
        checkOutput("hold_user", 32'(ob_user), 32'(hu));
        checkOutput("hold_last", 32'(ob_last), 32'(hl));
      end
      stalled = 0;
      if (ob_valid) begin
        if (tready) begin
          bd[cnt] = ob_data;
          bu[cnt] = ob_user;
          bl[cnt] = ob_last;
          idle_before[cnt] = idle;
          idle = 0;
          cnt++;
          if (cnt == drop_at) enable = 1'b0;
        end else begin
          stalled = 1;
          hd = ob_data;
          hu = ob_user;
          hl = ob_last;
        end
      end else begin
        idle++;
      end
    end
    if (cnt < n) checkOutput("beat_timeout", 32'(cnt), 32'(n));
    tready = 1'b1;
  endtask

  task automatic check_frame(input int n, input int s, input int fc_start);
    for (int i = 0; i < n; i++) begin
      int x, y, f;
      x = i % H;
      y = (i / H) % V;
      f = (fc_start + i / (H * V)) & 1;
      checkOutput($sformatf("pix%0d", i), 32'(bd[i]), 32'(exp_pix(s, x, y, f)));
      checkOutput($sformatf("tuser%0d", i), 32'(bu[i]), 32'((x == 0) && (y == 0)));
      checkOutput($sformatf("tlast%0d", i), 32'(bl[i]), 32'(x == H - 1));
    end
  endtask

  task automatic start_frame(input logic [1:0] s, input logic w);
    @(negedge aclk);
    which  = w;
    sel    = s;
    enable = 1'b1;
  endtask

  initial begin
    tests_run = 0;
    failures  = 0;
    aresetn   = 1'b0;
    enable    = 1'b0;
    sel       = 2'd0;
    tready    = 1'b1;
    which     = 1'b0;

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    checkOutput("rst_valid", 32'(valid0), 32'd0);
    checkOutput("rst_user", 32'(user0), 32'd0);
    checkOutput("rst_last", 32'(last0), 32'd0);
    checkOutput("rst_data", 32'(data0), 32'd0);
    checkOutput("rst_fc", 32'(fc0), 32'd0);
    checkOutput("rst_valid3", 32'(valid3), 32'd0);
    aresetn = 1'b1;

    // Solid red, single frame, full throughput
    start_frame(2'd0, 1'b0);
    applyStimulus(64, 0, 1);
    checkOutput("red_cycles", 32'(cyc_used), 32'd64);
    check_frame(64, 0, 0);
    @(negedge aclk);
    checkOutput("red_idle_valid", 32'(ob_valid), 32'd0);
    checkOutput("red_fc", 32'(ob_fc), 32'd1);

    // Checkerboard, two back-to-back frames with no bubble
    start_frame(2'd3, 1'b0);
    applyStimulus(128, 0, 65);
    checkOutput("chk_cycles", 32'(cyc_used), 32'd128);
    check_frame(128, 3, 1);
    @(negedge aclk);
    checkOutput("chk_idle_valid", 32'(ob_valid), 32'd0);
    checkOutput("chk_fc", 32'(ob_fc), 32'd3);

    // Colour bars
    start_frame(2'd1, 1'b0);
    applyStimulus(64, 0, 1);
    check_frame(64, 1, 3);
    @(negedge aclk);
    checkOutput("bar_fc", 32'(ob_fc), 32'd4);

    // Grey ramp with random backpressure
    start_frame(2'd2, 1'b0);
    applyStimulus(64, 1, 1);
    check_frame(64, 2, 4);
    @(negedge aclk);
    checkOutput("ramp_fc", 32'(ob_fc), 32'd5);

    // Reset in the middle of a frame, then restart
    start_frame(2'd0, 1'b0);
    applyStimulus(20, 0, 1000);
    aresetn = 1'b0;
    @(negedge aclk);
    checkOutput("mid_rst_valid", 32'(ob_valid), 32'd0);
    checkOutput("mid_rst_data", 32'(ob_data), 32'd0);
    checkOutput("mid_rst_user", 32'(ob_user), 32'd0);
    checkOutput("mid_rst_last", 32'(ob_last), 32'd0);
    checkOutput("mid_rst_fc", 32'(ob_fc), 32'd0);
    aresetn = 1'b1;
    applyStimulus(64, 0, 1);
    checkOutput("restart_cycles", 32'(cyc_used), 32'd64);
    check_frame(64, 0, 0);
    @(negedge aclk);
    checkOutput("restart_fc", 32'(ob_fc), 32'd1);

    // Line gap of 3, enable dropped at beat 10
    start_frame(2'd0, 1'b1);
    applyStimulus(64, 0, 10);
    checkOutput("gap_cycles", 32'(cyc_used), 32'd73);
    check_frame(64, 0, 0);
    for (int i = 1; i < 64; i++) begin
      checkOutput($sformatf("gap_idle%0d", i), 32'(idle_before[i]), (i % H == 0) ? 32'd3 : 32'd0);
    end
    repeat (5) @(negedge aclk);
    checkOutput("gap_end_valid", 32'(ob_valid), 32'd0);
    checkOutput("gap_fc", 32'(ob_fc), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
